// File: rtl/usb_stream_in.sv
// usb_stream_in: drains 16-bit samples from the read-back FIFO into a double-banked
// byte packet buffer and commits full, flushed or idle-timed-out packets to the IN endpoint.
module usb_stream_in #(
  parameter int PKT_BYTES    = 64,
  parameter int IDLE_TIMEOUT = 4800
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        flush,
  input  logic        fifo_empty,
  output logic        fifo_rd_en,
  input  logic [15:0] fifo_rd_data,
  output logic        buf_we,
  output logic [6:0]  buf_addr,
  output logic [7:0]  buf_wr_data,
  output logic [1:0]  pkt_valid,
  output logic [6:0]  pkt_len0,
  output logic [6:0]  pkt_len1,
  input  logic [1:0]  pkt_done,
  output logic        fill_bank,
  output logic        busy
);
  localparam int TW = IDLE_TIMEOUT > 0 ? $clog2(IDLE_TIMEOUT + 1) : 1;
  localparam logic [6:0] PB = 7'(PKT_BYTES);
  localparam logic [TW-1:0] TMAX = TW'(IDLE_TIMEOUT);
  typedef enum logic [1:0] {IDLE, LO, HI, WAITB} state_e;
  state_e        state_q;
  logic [6:0]    count_q;
  logic [7:0]    hi_q;
  logic          flush_q;
  logic [TW-1:0] tmo_q;
  logic          fb_q;
  logic [1:0]    valid_q;
  logic [6:0]    len0_q, len1_q;
  logic [6:0]    count_d, len_d;
  logic [1:0]    valid_d;
  logic          pend, tmo_hit, idle_commit, hi_commit, commit, pop;
  assign count_d     = count_q + 7'd1;
  assign pend        = flush | flush_q;
  assign tmo_hit     = (IDLE_TIMEOUT != 0) && (tmo_q == TMAX);
  assign idle_commit = (state_q == IDLE) && (count_q != 7'd0) && (pend || tmo_hit);
  assign hi_commit   = (state_q == HI) && (count_d == PB);
  assign commit      = idle_commit | hi_commit;
  assign len_d       = hi_commit ? count_d : count_q;
  assign valid_d     = valid_q & ~pkt_done;
  // Gated by rst_n so nothing is popped while reset is held.
  assign pop = rst_n && (state_q == IDLE) && !idle_commit && enable && !fifo_empty && !valid_q[fb_q];
  assign fifo_rd_en  = pop;
  assign buf_we      = (state_q == LO) || (state_q == HI);
  assign buf_addr    = {fb_q, count_q[5:0]};
  assign buf_wr_data = (state_q == LO) ? fifo_rd_data[7:0] : (state_q == HI) ? hi_q : 8'h00;
  assign pkt_valid   = valid_q;
  assign pkt_len0    = len0_q;
  assign pkt_len1    = len1_q;
  assign fill_bank   = fb_q;
  assign busy        = (state_q != IDLE) || (count_q != 7'd0);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      hi_q    <= '0;
      flush_q <= 1'b0;
      tmo_q   <= '0;
      fb_q    <= 1'b0;
      valid_q <= '0;
      len0_q  <= '0;
      len1_q  <= '0;
    end else begin
      valid_q <= valid_d;
      // A flush seen mid-word is held until the word is complete.
      flush_q <= ((state_q == LO) || (state_q == HI)) && pend;
      case (state_q)
        IDLE: begin
          if (pop) begin
            state_q <= LO;
            tmo_q   <= '0;
          end else if (!idle_commit && enable && valid_q[fb_q]) begin
            state_q <= WAITB;
          end else if ((count_q != 7'd0) && fifo_empty && (tmo_q != TMAX)) begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        LO: begin
          hi_q    <= fifo_rd_data[15:8];
          count_q <= count_d;
          state_q <= HI;
        end
        HI: begin
          count_q <= count_d;
          state_q <= IDLE;
        end
        default: if (!valid_q[fb_q]) state_q <= IDLE;
      endcase
      if (commit) begin
        valid_q[fb_q] <= 1'b1;
        if (fb_q) len1_q <= len_d;
        else len0_q <= len_d;
        fb_q    <= ~fb_q;
        count_q <= '0;
        tmo_q   <= '0;
        state_q <= valid_d[~fb_q] ? WAITB : IDLE;
      end
    end
  end
endmodule
